// File: rtl/ts_event_arbiter.sv
// Shares one event timestamper between N_REQ requesters: ID pool,
// round-robin start/end arbitration, end ownership checks, retire tagging.
module ts_event_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 4,
  parameter int OWN_W = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_start_valid,
  output logic [N_REQ-1:0]      req_start_ready,
  output logic [ID_W-1:0]       req_start_id,
  input  logic [N_REQ-1:0]      req_end_valid,
  output logic [N_REQ-1:0]      req_end_ready,
  input  logic [N_REQ*ID_W-1:0] req_end_id,
  output logic                  ts_start_valid,
  input  logic                  ts_start_ready,
  output logic [ID_W-1:0]       ts_start_id,
  output logic                  ts_end_valid,
  input  logic                  ts_end_ready,
  output logic [ID_W-1:0]       ts_end_id,
  input  logic                  ts_out_valid,
  input  logic                  ts_out_ready,
  input  logic [ID_W-1:0]       ts_out_id,
  output logic [OWN_W-1:0]      ts_out_owner,
  output logic [ID_W:0]         inflight_cnt,
  output logic                  err_bad_end,
  output logic                  err_bad_retire
);

  localparam int NID = 2 ** ID_W;

  logic [NID-1:0]   alloc_q, alloc_d;
  logic [NID-1:0]   ended_q, ended_d;
  logic [OWN_W-1:0] owner_q [NID];
  logic [OWN_W-1:0] rr_start_q, rr_start_d;
  logic [OWN_W-1:0] rr_end_q, rr_end_d;
  logic [ID_W:0]    cnt_q, cnt_d;
  logic             bad_end_q;
  logic             bad_ret_q;

  logic [ID_W-1:0]  free_id;
  logic             free_any;
  logic [OWN_W-1:0] st_win, st_idx;
  logic             st_any, st_fire;
  logic [OWN_W-1:0] en_win, en_idx;
  logic             en_any, en_fire;
  logic [N_REQ-1:0] end_ok, bad_end;
  logic [ID_W-1:0]  end_ids [N_REQ];
  logic             ret, ret_ok;

  function automatic logic [OWN_W-1:0] nxt(input logic [OWN_W-1:0] w);
    return (int'(w) == N_REQ - 1) ? '0 : OWN_W'(int'(w) + 1);
  endfunction

  // lowest free ID wins; descending loop leaves the lowest assignment
  always_comb begin
    free_id  = '0;
    free_any = 1'b0;
    for (int i = NID - 1; i >= 0; i--) begin
      if (!alloc_q[ID_W'(i)]) begin
        free_id  = ID_W'(i);
        free_any = 1'b1;
      end
    end
  end

  always_comb begin
    st_win = '0;
    st_any = 1'b0;
    st_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      st_idx = OWN_W'((int'(rr_start_q) + k) % N_REQ);
      if (req_start_valid[st_idx]) begin
        st_win = st_idx;
        st_any = 1'b1;
      end
    end
  end

  assign ts_start_valid = st_any && free_any;
  assign ts_start_id    = free_id;
  assign req_start_id   = free_id;
  assign st_fire        = ts_start_valid && ts_start_ready;

  always_comb begin
    req_start_ready = '0;
    if (st_fire) req_start_ready[st_win] = 1'b1;
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_end
    logic [ID_W-1:0] eid;
    assign eid        = req_end_id[g*ID_W +: ID_W];
    assign end_ids[g] = eid;
    assign end_ok[g]  = req_end_valid[g] && alloc_q[eid] &&
                        !ended_q[eid] && (owner_q[eid] == OWN_W'(g));
  end

  assign bad_end = req_end_valid & ~end_ok;

  always_comb begin
    en_win = '0;
    en_any = 1'b0;
    en_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      en_idx = OWN_W'((int'(rr_end_q) + k) % N_REQ);
      if (end_ok[en_idx]) begin
        en_win = en_idx;
        en_any = 1'b1;
      end
    end
  end

  assign ts_end_valid = en_any;
  assign ts_end_id    = end_ids[en_win];
  assign en_fire      = en_any && ts_end_ready;

  // rejected ends are acknowledged regardless of the arbiter
  always_comb begin
    req_end_ready = bad_end;
    if (en_fire) req_end_ready[en_win] = 1'b1;
  end

  assign ret    = ts_out_valid && ts_out_ready;
  assign ret_ok = ret && alloc_q[ts_out_id];

  always_comb begin
    alloc_d    = alloc_q;
    ended_d    = ended_q;
    rr_start_d = rr_start_q;
    rr_end_d   = rr_end_q;
    if (st_fire) begin
      alloc_d[free_id] = 1'b1;
      ended_d[free_id] = 1'b0;
      rr_start_d       = nxt(st_win);
    end
    if (en_fire) begin
      ended_d[ts_end_id] = 1'b1;
      rr_end_d           = nxt(en_win);
    end
    if (ret_ok) begin
      alloc_d[ts_out_id] = 1'b0;
      ended_d[ts_out_id] = 1'b0;
    end
    cnt_d = cnt_q + (ID_W+1)'(st_fire) - (ID_W+1)'(ret_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q    <= '0;
      ended_q    <= '0;
      rr_start_q <= '0;
      rr_end_q   <= '0;
      cnt_q      <= '0;
      bad_end_q  <= 1'b0;
      bad_ret_q  <= 1'b0;
    end else begin
      alloc_q    <= alloc_d;
      ended_q    <= ended_d;
      rr_start_q <= rr_start_d;
      rr_end_q   <= rr_end_d;
      cnt_q      <= cnt_d;
      bad_end_q  <= |bad_end;
      bad_ret_q  <= ret && !alloc_q[ts_out_id];
    end
  end

  // owner table needs no reset: it is only read behind alloc
  always_ff @(posedge clk) begin
    if (st_fire) owner_q[free_id] <= st_win;
  end

  assign ts_out_owner   = owner_q[ts_out_id];
  assign inflight_cnt   = cnt_q;
  assign err_bad_end    = bad_end_q;
  assign err_bad_retire = bad_ret_q;

endmodule
